// File: rtl/ram_arbiter_pkg.sv
// ram_arbiter_pkg
//   Constants shared by every RAM-side block: the command opcodes driven on
//   ram_instr, the arbiter FSM state encodings and the requester index width.
//   No ports; import with "import ram_arbiter_pkg::*;".
package ram_arbiter_pkg;

  // RAM controller opcodes (ram_instr)
  localparam logic OP_READ  = 1'b0;
  localparam logic OP_WRITE = 1'b1;

  // Arbiter FSM encodings, kept as plain constants for legacy tools
  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_ISSUE     = 2'd1;
  localparam logic [1:0] ST_WAIT_BUSY = 2'd2;
  localparam logic [1:0] ST_WAIT_DONE = 2'd3;

  // Requester index width; enough for the largest supported N_REQ (4)
  localparam int IDX_W = 2;

endpackage

// File: rtl/ram_arbiter_rr_select.sv
// rr_select
//   Combinational round-robin winner selection. The search starts at
//   (lastGrant + 1) mod N_REQ and walks upward with wrap; the first asserted
//   request wins.
// Ports:
//   req       in   N_REQ  request vector
//   lastGrant in   IDX_W  index of the most recent winner
//   winner    out  N_REQ  one-hot winner, all zero when no request
module rr_select
  import ram_arbiter_pkg::*;
#(
  parameter int N_REQ = 3
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] lastGrant,
  output logic [N_REQ-1:0] winner
);

  typedef logic [IDX_W:0] cand_t;

  cand_t candIdx_s;
  logic  found_s;

  // Try candidates lastGrant+1 .. lastGrant+N_REQ (mod N_REQ), first hit wins
  always_comb begin
    winner    = '0;
    found_s   = 1'b0;
    candIdx_s = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      candIdx_s = {1'b0, lastGrant} + cand_t'(k);
      // lastGrant < N_REQ and k <= N_REQ, so one subtraction is a full modulo
      if (candIdx_s >= cand_t'(N_REQ)) begin
        candIdx_s = candIdx_s - cand_t'(N_REQ);
      end else begin
        candIdx_s = candIdx_s;
      end
      for (int i = 0; i < N_REQ; i++) begin
        if (!found_s && req[i] && (candIdx_s == cand_t'(i))) begin
          winner[i] = 1'b1;
          found_s   = 1'b1;
        end else begin
          winner[i] = winner[i];
        end
      end
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter
//   Shares one RAM controller between N_REQ requesters. A round-robin winner
//   is granted in IDLE, its command is strobed once with ram_latch, and the
//   grant is held until the controller reports completion; a controller whose
//   ram_ready never drops is treated as complete after BUSY_WAIT cycles.
// Ports:
//   clk, rst             clock and synchronous active-high reset
//   req/we/addr/wdata    per-requester request, opcode, word address, data
//   gnt                  one-hot grant, held for the whole transaction
//   done                 one-cycle completion pulse to the granted requester
//   rdata                read data, valid in the cycle done pulses
//   ram_instr/ram_latch  opcode and one-cycle strobe to the RAM controller
//   ram_addr/ram_wdata   registered address and write data to the controller
//   ram_rdata/ram_ready  read data and idle/complete from the controller
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int N_REQ     = 3,
  parameter int ADDR_W    = 23,
  parameter int DATA_W    = 16,
  parameter int BUSY_WAIT = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ-1:0]          we,
  input  logic [N_REQ*ADDR_W-1:0]   addr,
  input  logic [N_REQ*DATA_W-1:0]   wdata,
  output logic [N_REQ-1:0]          gnt,
  output logic [N_REQ-1:0]          done,
  output logic [DATA_W-1:0]         rdata,
  output logic                      ram_instr,
  output logic                      ram_latch,
  output logic [ADDR_W-1:0]         ram_addr,
  output logic [DATA_W-1:0]         ram_wdata,
  input  logic [DATA_W-1:0]         ram_rdata,
  input  logic                      ram_ready
);

  localparam int CNT_W = (BUSY_WAIT > 1) ? $clog2(BUSY_WAIT) : 1;

  logic [1:0]        state_r;
  logic [IDX_W-1:0]  lastGrant_r;
  logic [CNT_W-1:0]  busyCnt_r;

  logic [N_REQ-1:0]  winner_s;
  logic              selWe_s;
  logic [ADDR_W-1:0] selAddr_s;
  logic [DATA_W-1:0] selWdata_s;
  logic [IDX_W-1:0]  selIdx_s;

  rr_select #(
    .N_REQ (N_REQ)
  ) u_rrSelect (
    .req       (req),
    .lastGrant (lastGrant_r),
    .winner    (winner_s)
  );

  // Route the winning requester's opcode, address, data and index
  always_comb begin
    selWe_s    = 1'b0;
    selAddr_s  = '0;
    selWdata_s = '0;
    selIdx_s   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (winner_s[i]) begin
        selWe_s    = we[i];
        selAddr_s  = addr[i*ADDR_W +: ADDR_W];
        selWdata_s = wdata[i*DATA_W +: DATA_W];
        selIdx_s   = IDX_W'(i);
      end else begin
        selWe_s    = selWe_s;
      end
    end
  end

  // Arbiter FSM and all registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      lastGrant_r <= IDX_W'(N_REQ - 1);
      busyCnt_r   <= '0;
      gnt         <= '0;
      done        <= '0;
      rdata       <= '0;
      ram_instr   <= OP_READ;
      ram_latch   <= 1'b0;
      ram_addr    <= '0;
      ram_wdata   <= '0;
    end else begin
      // Strobes default low so each is high for one cycle only
      ram_latch <= 1'b0;
      done      <= '0;
      case (state_r)
        ST_IDLE: begin
          // Requester inputs are sampled only here; a busy controller blocks grants
          if (ram_ready && (|req)) begin
            gnt         <= winner_s;
            lastGrant_r <= selIdx_s;
            ram_instr   <= selWe_s;
            ram_addr    <= selAddr_s;
            ram_wdata   <= selWdata_s;
            ram_latch   <= 1'b1;
            state_r     <= ST_ISSUE;
          end else begin
            state_r     <= ST_IDLE;
          end
        end
        ST_ISSUE: begin
          busyCnt_r <= '0;
          state_r   <= ST_WAIT_BUSY;
        end
        ST_WAIT_BUSY: begin
          // Either the controller acknowledges by going busy, or we give up
          // waiting and treat the operation as already finished
          if (!ram_ready) begin
            state_r   <= ST_WAIT_DONE;
          end else if (busyCnt_r == CNT_W'(BUSY_WAIT - 1)) begin
            state_r   <= ST_WAIT_DONE;
          end else begin
            busyCnt_r <= busyCnt_r + CNT_W'(1);
          end
        end
        ST_WAIT_DONE: begin
          if (ram_ready) begin
            if (ram_instr == OP_READ) begin
              rdata <= ram_rdata;
            end else begin
              rdata <= rdata;
            end
            done    <= gnt;
            gnt     <= '0;
            state_r <= ST_IDLE;
          end else begin
            state_r <= ST_WAIT_DONE;
          end
        end
        default: begin
          gnt     <= '0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter
//   Self-checking bench for ram_arbiter. A behavioural RAM controller drives
//   ram_ready/ram_rdata; a transaction-level reference model (round-robin
//   pick by arithmetic, memory as an associative array) predicts winner,
//   latency, command fields and read data.
module tb_ram_arbiter;

  localparam int N  = 3;
  localparam int AW = 23;
  localparam int DW = 16;
  localparam int BW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [N-1:0]  req, we;
  logic [N*AW-1:0] addr;
  logic [N*DW-1:0] wdata;
  logic [N-1:0]  gnt, done;
  logic [DW-1:0] rdata;
  logic          ram_instr, ram_latch;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata = '0;
  logic          ram_ready = 1'b1;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  ram_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .BUSY_WAIT(BW)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .gnt(gnt), .done(done), .rdata(rdata),
    .ram_instr(ram_instr), .ram_latch(ram_latch), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .ram_ready(ram_ready)
  );

  always @(posedge clk) cycle++;

  // ---------------- behavioural RAM controller ----------------
  int busyCycles = 3;   // 0 = ready never drops
  int busyLeft   = 0;
  int latchCount = 0;
  logic          lastInstr;
  logic [AW-1:0] lastAddr;
  logic [DW-1:0] lastWdata;
  logic [DW-1:0] ctrlMem [int];

  function automatic logic [DW-1:0] bgData(input logic [AW-1:0] a);
    return a[DW-1:0] ^ 16'hC3A5;
  endfunction

  always @(posedge clk) begin
    if (ram_latch === 1'b1) begin
      latchCount++;
      lastInstr = ram_instr;
      lastAddr  = ram_addr;
      lastWdata = ram_wdata;
      if (ram_instr) ctrlMem[int'(ram_addr)] = ram_wdata;
      else ram_rdata <= ctrlMem.exists(int'(ram_addr)) ? ctrlMem[int'(ram_addr)] : bgData(ram_addr);
      if (busyCycles > 0) begin
        ram_ready <= 1'b0;
        busyLeft = busyCycles;
      end
    end else if (busyLeft > 0) begin
      busyLeft--;
      if (busyLeft == 0) ram_ready <= 1'b1;
    end
  end

  // ---------------- reference model ----------------
  int modelLast;
  logic [DW-1:0] expRdata;
  logic [DW-1:0] refMem [int];

  function automatic logic [DW-1:0] refRead(input logic [AW-1:0] a);
    return refMem.exists(int'(a)) ? refMem[int'(a)] : bgData(a);
  endfunction

  function automatic int rrPick(input logic [N-1:0] m, input int last);
    for (int k = 1; k <= N; k++) begin
      if (m[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  // Grant edge to done: ISSUE, one WAIT_BUSY cycle, then busy time in
  // WAIT_DONE; a controller that never goes busy costs BW WAIT_BUSY cycles.
  function automatic int expLatency(input int busy);
    return (busy > 0) ? busy + 2 : BW + 2;
  endfunction

  task automatic modelCommit(input int w);
    modelLast = w;
    if (we[w]) refMem[int'(addr[w*AW +: AW])] = wdata[w*DW +: DW];
    else expRdata = refRead(addr[w*AW +: AW]);
  endtask

  task automatic setReq(input int i, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    we[i] = w;
    addr[i*AW +: AW] = a;
    wdata[i*DW +: DW] = d;
  endtask

  function automatic int ohIdx(input logic [N-1:0] g);
    for (int i = 0; i < N; i++) if (g[i]) return i;
    return -1;
  endfunction

  // ---------------- transaction driver / observer ----------------
  int obsWinner, obsGntCyc, obsDoneCyc, obsLatches, obsDoneIdx;
  logic obsTimeout, obsGntStable, obsOneHot;
  logic [N-1:0]  obsGntAtDone;
  logic [DW-1:0] obsRdata;

  // Drive req=mask, drop all requests dropAfter cycles after the grant, wait for done
  task automatic runOne(input logic [N-1:0] mask, input int dropAfter);
    int l0, n;
    logic [N-1:0] g;
    l0 = latchCount;
    obsTimeout = 1'b0; obsGntStable = 1'b1; obsOneHot = 1'b1; obsWinner = -1; obsDoneIdx = -1;
    req = mask;
    n = 0;
    do begin @(negedge clk); n++; end while (gnt == '0 && n < 30);
    if (gnt == '0) begin obsTimeout = 1'b1; req = '0; return; end
    g = gnt; obsGntCyc = cycle; obsWinner = ohIdx(g);
    n = 0;
    while (done == '0 && n < 60) begin
      if (n == dropAfter) req = '0;
      if (gnt !== g) obsGntStable = 1'b0;
      if ($countones(gnt) > 1) obsOneHot = 1'b0;
      @(negedge clk); n++;
    end
    req = '0;
    if (done == '0) begin obsTimeout = 1'b1; return; end
    if ($countones(done) > 1) obsOneHot = 1'b0;
    obsDoneCyc = cycle; obsDoneIdx = ohIdx(done); obsRdata = rdata;
    obsGntAtDone = gnt; obsLatches = latchCount - l0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1; req = 3'($urandom); we = 3'($urandom);
    addr = {3{23'($urandom)}}; wdata = {3{16'($urandom)}};
    repeat (3) @(negedge clk);
    rst = 1'b0; req = '0; modelLast = N - 1; expRdata = '0;
    checks++; if (gnt !== 3'b000) begin errors++; $display("FAIL reset_gnt: got %b expected 000", gnt); end
    checks++; if (done !== 3'b000) begin errors++; $display("FAIL reset_done: got %b expected 000", done); end
    checks++; if (ram_latch !== 1'b0) begin errors++; $display("FAIL reset_latch: got %b expected 0", ram_latch); end
    checks++; if (ram_instr !== 1'b0) begin errors++; $display("FAIL reset_instr: got %b expected 0", ram_instr); end
    checks++; if (ram_addr !== 23'h0) begin errors++; $display("FAIL reset_addr: got %h expected 0", ram_addr); end
    checks++; if (ram_wdata !== 16'h0) begin errors++; $display("FAIL reset_wdata: got %h expected 0", ram_wdata); end
    checks++; if (rdata !== 16'h0) begin errors++; $display("FAIL reset_rdata: got %h expected 0", rdata); end
  endtask

  task automatic test_single_write();
    int expW;
    busyCycles = 3;
    setReq(0, 1'b1, 23'h000010, 16'h00AB);
    expW = rrPick(3'b001, modelLast);
    modelCommit(expW);
    runOne(3'b001, 0);
    checks++; if (obsTimeout) begin errors++; $display("FAIL write_timeout: got timeout expected done"); end
    checks++; if (obsDoneIdx !== expW) begin errors++; $display("FAIL write_done_idx: got %0d expected %0d", obsDoneIdx, expW); end
    checks++; if (obsLatches !== 1) begin errors++; $display("FAIL write_latches: got %0d expected 1", obsLatches); end
    checks++; if (lastInstr !== 1'b1) begin errors++; $display("FAIL write_instr: got %b expected 1", lastInstr); end
    checks++; if (lastAddr !== 23'h10 || lastWdata !== 16'h00AB) begin errors++; $display("FAIL write_cmd: got %h/%h expected 10/00ab", lastAddr, lastWdata); end
    checks++; if (obsDoneCyc - obsGntCyc !== expLatency(3)) begin errors++; $display("FAIL write_latency: got %0d expected %0d", obsDoneCyc - obsGntCyc, expLatency(3)); end
    checks++; if (obsRdata !== expRdata) begin errors++; $display("FAIL write_rdata_kept: got %h expected %h", obsRdata, expRdata); end
    checks++; if (obsGntAtDone !== 3'b000) begin errors++; $display("FAIL write_gnt_cleared: got %b expected 000", obsGntAtDone); end
  endtask

  task automatic test_single_read();
    int expW;
    busyCycles = 2;
    setReq(1, 1'b0, 23'h000020, 16'hFFFF);
    expW = rrPick(3'b010, modelLast);
    modelCommit(expW);
    runOne(3'b010, 100);
    checks++; if (obsWinner !== expW) begin errors++; $display("FAIL read_winner: got %0d expected %0d", obsWinner, expW); end
    checks++; if (obsRdata !== expRdata) begin errors++; $display("FAIL read_rdata: got %h expected %h", obsRdata, expRdata); end
    checks++; if (!obsGntStable) begin errors++; $display("FAIL read_gnt_held: got unstable expected 010 throughout"); end
    checks++; if (lastInstr !== 1'b0 || lastAddr !== 23'h20) begin errors++; $display("FAIL read_cmd: got %b/%h expected 0/20", lastInstr, lastAddr); end
  endtask

  task automatic test_contention();
    int expW, busy, n, prevDone, l0;
    rst = 1'b1; req = '0; @(negedge clk); rst = 1'b0;
    modelLast = N - 1; expRdata = '0;
    for (int i = 0; i < N; i++) setReq(i, 1'($urandom), 23'($urandom_range(0, 15)), 16'($urandom));
    l0 = latchCount; prevDone = -1;
    req = 3'b111;
    for (int t = 0; t < 6; t++) begin
      busy = $urandom_range(0, 3); busyCycles = busy;
      expW = rrPick(3'b111, modelLast);
      modelCommit(expW);
      n = 0;
      do begin @(negedge clk); n++; end while (done == '0 && n < 40);
      checks++; if (done !== (3'b001 << expW)) begin errors++; $display("FAIL contention_done t=%0d: got %b expected %b", t, done, 3'b001 << expW); end
      checks++; if (rdata !== expRdata) begin errors++; $display("FAIL contention_rdata t=%0d: got %h expected %h", t, rdata, expRdata); end
      if (t > 0) begin
        checks++; if (cycle - prevDone !== expLatency(busy) + 1) begin errors++; $display("FAIL contention_interval t=%0d: got %0d expected %0d", t, cycle - prevDone, expLatency(busy) + 1); end
      end
      prevDone = cycle;
    end
    req = '0;
    @(negedge clk);
    checks++; if (latchCount - l0 !== 6) begin errors++; $display("FAIL contention_latches: got %0d expected 6", latchCount - l0); end
  endtask

  task automatic test_stuck_ready();
    int expW;
    busyCycles = 0;
    setReq(2, 1'b0, 23'h000007, 16'h0);
    expW = rrPick(3'b100, modelLast);
    modelCommit(expW);
    runOne(3'b100, 0);
    checks++; if (obsDoneIdx !== expW) begin errors++; $display("FAIL stuck_done_idx: got %0d expected %0d", obsDoneIdx, expW); end
    checks++; if (obsDoneCyc - obsGntCyc !== expLatency(0)) begin errors++; $display("FAIL stuck_latency: got %0d expected %0d", obsDoneCyc - obsGntCyc, expLatency(0)); end
    checks++; if (obsRdata !== expRdata) begin errors++; $display("FAIL stuck_rdata: got %h expected %h", obsRdata, expRdata); end
    @(negedge clk);
    checks++; if (gnt !== 3'b000 || ram_latch !== 1'b0) begin errors++; $display("FAIL stuck_idle: got gnt=%b latch=%b expected 000/0", gnt, ram_latch); end
    busyCycles = 1;
    setReq(0, 1'b1, 23'h000003, 16'h5A5A);
    expW = rrPick(3'b001, modelLast);
    modelCommit(expW);
    runOne(3'b001, 0);
    checks++; if (obsDoneIdx !== expW || obsTimeout) begin errors++; $display("FAIL stuck_recover: got %0d expected %0d", obsDoneIdx, expW); end
  endtask

  task automatic test_reset_mid();
    int n, l0, expW;
    logic sawGnt, sawDone;
    busyCycles = 8;
    for (int i = 0; i < N; i++) setReq(i, 1'b0, 23'(i + 9), 16'h0);
    l0 = latchCount;
    req = 3'b001;
    n = 0;
    do begin @(negedge clk); n++; end while (gnt == '0 && n < 30);
    req = '0;
    repeat (3) @(negedge clk);
    checks++; if (gnt !== 3'b001) begin errors++; $display("FAIL rstmid_held: got %b expected 001", gnt); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; modelLast = N - 1; expRdata = '0;
    checks++; if (gnt !== 3'b000 || done !== 3'b000) begin errors++; $display("FAIL rstmid_clear: got gnt=%b done=%b expected 000/000", gnt, done); end
    checks++; if (ram_latch !== 1'b0 || rdata !== 16'h0) begin errors++; $display("FAIL rstmid_outs: got latch=%b rdata=%h expected 0/0", ram_latch, rdata); end
    checks++; if (latchCount - l0 !== 1) begin errors++; $display("FAIL rstmid_latches: got %0d expected 1", latchCount - l0); end
    req = 3'b111; sawGnt = 1'b0; sawDone = 1'b0; n = 0;
    while (ram_ready === 1'b0 && n < 40) begin
      if (gnt != '0) sawGnt = 1'b1;
      if (done != '0) sawDone = 1'b1;
      @(negedge clk); n++;
    end
    checks++; if (sawGnt || sawDone) begin errors++; $display("FAIL rstmid_busy_block: got gnt=%b done=%b expected no grant and no done", sawGnt, sawDone); end
    busyCycles = 1;
    expW = rrPick(3'b111, modelLast);
    modelCommit(expW);
    runOne(3'b111, 0);
    checks++; if (obsWinner !== expW) begin errors++; $display("FAIL rstmid_first: got %0d expected %0d", obsWinner, expW); end
    checks++; if (obsRdata !== expRdata) begin errors++; $display("FAIL rstmid_rdata: got %h expected %h", obsRdata, expRdata); end
  endtask

  task automatic test_drop_during_busy();
    int expW;
    busyCycles = 3;
    setReq(0, 1'b1, 23'h000033, 16'hBEEF);
    expW = rrPick(3'b001, modelLast);
    modelCommit(expW);
    runOne(3'b001, 2);
    checks++; if (obsDoneIdx !== expW || obsTimeout) begin errors++; $display("FAIL drop_done: got %0d expected %0d", obsDoneIdx, expW); end
    checks++; if (obsLatches !== 1) begin errors++; $display("FAIL drop_latches: got %0d expected 1", obsLatches); end
  endtask

  task automatic test_random();
    int expW, busy;
    logic [N-1:0] mask;
    logic expInstr;
    logic [AW-1:0] expAddr;
    logic [DW-1:0] expWdata;
    for (int t = 0; t < 25; t++) begin
      for (int i = 0; i < N; i++) setReq(i, 1'($urandom), 23'($urandom_range(0, 15)), 16'($urandom));
      mask = 3'($urandom_range(1, 7));
      busy = $urandom_range(0, 4); busyCycles = busy;
      expW = rrPick(mask, modelLast);
      expInstr = we[expW]; expAddr = addr[expW*AW +: AW]; expWdata = wdata[expW*DW +: DW];
      modelCommit(expW);
      runOne(mask, $urandom_range(0, 3));
      checks++; if (obsWinner !== expW || obsDoneIdx !== expW) begin errors++; $display("FAIL rand_winner t=%0d: got %0d/%0d expected %0d", t, obsWinner, obsDoneIdx, expW); end
      checks++; if (obsDoneCyc - obsGntCyc !== expLatency(busy)) begin errors++; $display("FAIL rand_latency t=%0d: got %0d expected %0d", t, obsDoneCyc - obsGntCyc, expLatency(busy)); end
      checks++; if (lastInstr !== expInstr || lastAddr !== expAddr) begin errors++; $display("FAIL rand_cmd t=%0d: got %b/%h expected %b/%h", t, lastInstr, lastAddr, expInstr, expAddr); end
      checks++; if (expInstr && lastWdata !== expWdata) begin errors++; $display("FAIL rand_wdata t=%0d: got %h expected %h", t, lastWdata, expWdata); end
      checks++; if (obsRdata !== expRdata) begin errors++; $display("FAIL rand_rdata t=%0d: got %h expected %h", t, obsRdata, expRdata); end
      checks++; if (obsLatches !== 1 || !obsGntStable || !obsOneHot) begin errors++; $display("FAIL rand_protocol t=%0d: got latches=%0d stable=%b onehot=%b expected 1/1/1", t, obsLatches, obsGntStable, obsOneHot); end
    end
  endtask

  initial begin
    ctrlMem[32'h20] = 16'h1234;
    refMem[32'h20]  = 16'h1234;
    test_reset();
    test_single_write();
    test_single_read();
    test_contention();
    test_stuck_ready();
    test_reset_mid();
    test_drop_during_busy();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 The block SHALL have parameter N_REQ, default 3, number of requesters (2..4).
REQ-002 The block SHALL have parameter ADDR_W, default 23, RAM word-address width (MemAdr[23:1]).
REQ-003 The block SHALL have parameter DATA_W, default 16, RAM data width.
REQ-004 The block SHALL have parameter BUSY_WAIT, default 4, cycles allowed for ram_ready to drop after a latch.
REQ-005 The block SHALL use one clock and a synchronous, active-high reset, with these ports in this order:
 clk  in  1  system clock, all logic on rising edge
 rst  in  1  synchronous active-high reset
 req  in  N_REQ  per-requester transaction request, level
 we  in  N_REQ  per-requester op: 1=WRITE, 0=READ
 addr  in  N_REQ*ADDR_W  packed per-requester word addresses
 wdata  in  N_REQ*DATA_W  packed per-requester write data
 gnt  out  N_REQ  one-hot grant, held for the whole transaction
 done  out  N_REQ  one-cycle completion pulse to the granted requester
 rdata  out  DATA_W  captured read data, valid in the cycle done pulses
 ram_instr  out  1  to RAM controller: READ=0, WRITE=1
 ram_latch  out  1  to RAM controller: one-cycle command strobe
 ram_addr  out  ADDR_W  to RAM controller address
 ram_wdata  out  DATA_W  to RAM controller write data
 ram_rdata  in  DATA_W  from RAM controller read data
 ram_ready  in  1  from RAM controller: idle/complete

Function
REQ-006 The FSM SHALL have states IDLE, ISSUE, WAIT_BUSY, WAIT_DONE.
REQ-007 IDLE: when ram_ready=1 and any req=1, it SHALL select a winner round-robin, set gnt one-hot, latch that requester's we/addr/wdata into ram_instr/ram_addr/ram_wdata, and go to ISSUE next cycle.
REQ-008 Round-robin SHALL search from index (last_grant+1) mod N_REQ upward with wrap; last_grant updates on each grant.
REQ-009 ISSUE SHALL assert ram_latch for exactly one cycle, then go to WAIT_BUSY.
REQ-010 WAIT_BUSY SHALL go to WAIT_DONE on ram_ready=0; if ram_ready stays 1 for BUSY_WAIT cycles, it SHALL treat the op as complete and go to WAIT_DONE.
REQ-011 WAIT_DONE SHALL wait for ram_ready=1; that cycle it SHALL capture ram_rdata into rdata (READ only; rdata unchanged on WRITE), pulse done[winner] for one cycle, clear gnt, and return to IDLE.
REQ-012 Minimum request-to-done latency SHALL be 4 cycles (IDLE grant, ISSUE, WAIT_BUSY, WAIT_DONE), plus the controller's busy time.
REQ-013 ram_instr/ram_addr/ram_wdata SHALL be registered and stable from ISSUE through done; requester inputs are sampled only at grant.
REQ-014 A req dropped before grant SHALL be ignored; a req dropped while granted SHALL NOT abort the transaction — done still pulses.
REQ-015 A requester re-asserting req in its done cycle SHALL compete normally at the next IDLE evaluation; a second requester pending SHALL win first (fairness).
REQ-016 No new grant SHALL occur while ram_ready=0 in IDLE.
REQ-017 At most one gnt bit and at most one done bit SHALL be high in any cycle.

Reset
REQ-018 On rst=1 at a rising edge: state=IDLE, gnt=0, done=0, ram_latch=0, ram_instr=0 (READ), ram_addr=0, ram_wdata=0, rdata=0, busy counter=0, last_grant=N_REQ-1 (requester 0 first).
REQ-019 Reset mid-transaction SHALL abandon it without a done pulse; ram_latch SHALL be 0 the cycle after reset is sampled.

Structure
REQ-020 READ/WRITE opcode constants and state encodings SHALL live in a shared package used by all RAM-side blocks.
REQ-021 The round-robin selector SHALL be one sub-module, rr_select (inputs req, last_grant; output one-hot winner).

Verification
REQ-022 Single write: req=001, we0=1, addr0=0x000010, wdata0=0x00AB, controller busy 3 cycles -> one ram_latch pulse, ram_instr=1, ram_addr=0x10, done[0] 7 cycles after req.
REQ-023 Single read: req=010, addr1=0x000020, model returns 0x1234 -> done[1] with rdata=0x1234, gnt=010 throughout.
REQ-024 Contention: req=111 held for 6 transactions -> grant order 0,1,2,0,1,2, exactly one done per transaction.
REQ-025 Stuck-ready controller (ram_ready never drops) -> done after BUSY_WAIT=4 cycles in WAIT_BUSY, FSM back to IDLE.
REQ-026 rst asserted in WAIT_DONE -> no done pulse, gnt=0, next req=100 is granted to requester 0's priority order (0 first if also requesting).
REQ-027 req[0] dropped during WAIT_BUSY -> done[0] still pulses; controller sees exactly one latch.
